mips_mem_arbiter: RTL and testbench

Shares the CPU's single Avalon-MM memory master port between the instruction-fetch requester and the load/store (data) requester. Sits between the multi-cycle control path (FETCH_INSTR / MEMORY_ACCESS phases) and the external memory bus. Serialises accesses, absorbs `waitrequest` and returns read data with a one-cycle done pulse. The control path uses `busy` and `*_done` to stall its phase sequencing.

---
 rtl/mips_mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mips_mem_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mips_mem_arbiter.sv
// Arbitrates one Avalon-MM master port between instruction fetch and load/store.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; the default gives data fixed priority.
module mips_mem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_read,
    input  logic [31:0] i_address,
    output logic [31:0] i_readdata,
    output logic        i_done,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_address,
    input  logic [31:0] d_writedata,
    input  logic [3:0]  d_byteenable,
    output logic [31:0] d_readdata,
    output logic        d_done,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, GNT_I, GNT_D, RD_WAIT, DONE} state_t;

    state_t      state_q;
    logic        own_d_q;        // grant owner: 1 = data port
    logic        wr_q;
    logic        busy_q;
    logic        i_done_q, d_done_q;
    logic [31:0] i_rdata_q, d_rdata_q;
    logic [31:0] avm_addr_q, avm_wdata_q;
    logic [3:0]  avm_be_q;
    logic        avm_rd_q, avm_wr_q;
    logic        d_req;
    logic        grant_d_d;

    assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d_q;              // last grant: 1 = data
    assign grant_d_d = d_req & (~i_read | ~last_d_q);
`else
    assign grant_d_d = d_req;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            own_d_q     <= 1'b0;
            wr_q        <= 1'b0;
            busy_q      <= 1'b0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            avm_addr_q  <= '0;
            avm_wdata_q <= '0;
            avm_be_q    <= '0;
            avm_rd_q    <= 1'b0;
            avm_wr_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q    <= 1'b1;
`endif
        end else begin
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_read | d_req) begin
                        busy_q  <= 1'b1;
                        own_d_q <= grant_d_d;
`ifdef ARB_ROUND_ROBIN_EN
                        last_d_q <= grant_d_d;
`endif
                        if (grant_d_d) begin
                            state_q     <= GNT_D;
                            wr_q        <= d_write;
                            avm_addr_q  <= d_address;
                            avm_wdata_q <= d_writedata;
                            avm_be_q    <= d_byteenable;
                            avm_wr_q    <= d_write;
                            avm_rd_q    <= ~d_write;
                        end else begin
                            state_q     <= GNT_I;
                            wr_q        <= 1'b0;
                            avm_addr_q  <= i_address;
                            avm_wdata_q <= '0;
                            avm_be_q    <= 4'b1111;
                            avm_rd_q    <= 1'b1;
                        end
                    end
                end
                GNT_I, GNT_D: begin
                    if (!avm_waitrequest) begin
                        avm_rd_q <= 1'b0;
                        avm_wr_q <= 1'b0;
                        if (wr_q) begin
                            state_q  <= DONE;
                            d_done_q <= 1'b1;
                        end else begin
                            state_q <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    state_q <= DONE;
                    if (own_d_q) begin
                        d_rdata_q <= avm_readdata;
                        d_done_q  <= 1'b1;
                    end else begin
                        i_rdata_q <= avm_readdata;
                        i_done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign i_readdata     = i_rdata_q;
    assign i_done         = i_done_q;
    assign d_readdata     = d_rdata_q;
    assign d_done         = d_done_q;
    assign avm_address    = avm_addr_q;
    assign avm_read       = avm_rd_q;
    assign avm_write      = avm_wr_q;
    assign avm_writedata  = avm_wdata_q;
    assign avm_byteenable = avm_be_q;
    assign busy           = busy_q;
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: fetch, stalled write, tie, reset abort, held requests.
module tb_mips_mem_arbiter;
    logic        clk, reset;
    logic        i_read;
    logic [31:0] i_address, i_readdata;
    logic        i_done;
    logic        d_read, d_write;
    logic [31:0] d_address, d_writedata, d_readdata;
    logic [3:0]  d_byteenable;
    logic        d_done;
    logic [31:0] avm_address, avm_writedata, avm_readdata;
    logic        avm_read, avm_write, avm_waitrequest;
    logic [3:0]  avm_byteenable;
    logic        busy;

    int ntests = 0;
    int nfail  = 0;

    mips_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_done(i_done),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
        .d_byteenable(d_byteenable), .d_readdata(d_readdata), .d_done(d_done),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after the grant edge of a zero-wait read; drops the request in DONE.
    task automatic serve_read(input bit is_d, input logic [31:0] addr, input logic [31:0] data,
                              input string tag);
        check({tag, "_strobe"}, {31'd0, avm_read}, 32'd1);
        check({tag, "_addr"}, avm_address, addr);
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        step();
        check({tag, "_strobe_drop"}, {31'd0, avm_read}, 32'd0);
        avm_readdata = data;
        step();
        avm_readdata = 32'hBADBAD00;
        if (is_d) begin
            check({tag, "_d_done"}, {31'd0, d_done}, 32'd1);
            check({tag, "_i_done_quiet"}, {31'd0, i_done}, 32'd0);
            check({tag, "_d_rdata"}, d_readdata, data);
            d_read = 1'b0;
        end else begin
            check({tag, "_i_done"}, {31'd0, i_done}, 32'd1);
            check({tag, "_d_done_quiet"}, {31'd0, d_done}, 32'd0);
            check({tag, "_i_rdata"}, i_readdata, data);
            i_read = 1'b0;
        end
        step();
        check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done_off"}, {30'd0, i_done, d_done}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; i_read = 0; i_address = 0; d_read = 0; d_write = 0;
        d_address = 0; d_writedata = 0; d_byteenable = 0;
        avm_readdata = 32'hBADBAD00; avm_waitrequest = 0;
        step(); step();
        check("rst_strobes", {30'd0, avm_read, avm_write}, 32'd0);
        check("rst_addr", avm_address, 32'd0);
        check("rst_be", {28'd0, avm_byteenable}, 32'd0);
        check("rst_busy_done", {29'd0, busy, i_done, d_done}, 32'd0);
        check("rst_rdata", i_readdata | d_readdata, 32'd0);
        reset = 1'b0;
        step();

        // Boot fetch, zero wait
        i_read = 1; i_address = 32'hBFC00000;
        step();
        check("f1_be", {28'd0, avm_byteenable}, 32'hF);
        serve_read(1'b0, 32'hBFC00000, 32'h24020005, "f1");
        check("f1_rdata_hold", i_readdata, 32'h24020005);

        // Store with three waitrequest cycles; requester address changes after grant
        d_write = 1; d_address = 32'h1000; d_writedata = 32'hDEADBEEF; d_byteenable = 4'b0011;
        avm_waitrequest = 1;
        step();
        d_address = 32'h2000; d_writedata = 32'h0; d_byteenable = 4'hF;
        for (int k = 0; k < 4; k++) begin
            check("w_strobe", {30'd0, avm_write, avm_read}, 32'd2);
            check("w_addr", avm_address, 32'h1000);
            check("w_data", avm_writedata, 32'hDEADBEEF);
            check("w_be", {28'd0, avm_byteenable}, 32'h3);
            check("w_no_done", {31'd0, d_done}, 32'd0);
            if (k == 3) avm_waitrequest = 0;
            step();
        end
        check("w_strobe_drop", {31'd0, avm_write}, 32'd0);
        check("w_done", {31'd0, d_done}, 32'd1);
        d_write = 0;
        step();
        check("w_done_off", {31'd0, d_done}, 32'd0);
        check("w_busy_off", {31'd0, busy}, 32'd0);

        // Tie: instruction and data read together
        i_read = 1; i_address = 32'h100; d_read = 1; d_address = 32'h200;
        step();
`ifdef ARB_ROUND_ROBIN_EN
        serve_read(1'b0, 32'h100, 32'h11112222, "tie_first_i");
        step();
        serve_read(1'b1, 32'h200, 32'hD0D0D0D0, "tie_second_d");
`else
        serve_read(1'b1, 32'h200, 32'hD0D0D0D0, "tie_first_d");
        step();
        serve_read(1'b0, 32'h100, 32'h11112222, "tie_second_i");
`endif

        // Reset during RD_WAIT
        d_read = 1; d_address = 32'h300;
        step();
        step();
        reset = 1; d_read = 0; avm_readdata = 32'h55555555;
        step();
        check("ra_strobes", {30'd0, avm_read, avm_write}, 32'd0);
        check("ra_busy_done", {29'd0, busy, i_done, d_done}, 32'd0);
        check("ra_rdata", i_readdata | d_readdata, 32'd0);
        reset = 0;
        step();
        check("ra_no_done", {30'd0, i_done, d_done}, 32'd0);
        i_read = 1; i_address = 32'h400;
        step();
        serve_read(1'b0, 32'h400, 32'hCAFEF00D, "ra_after");

        // Back-to-back fetches, request held through DONE
        i_read = 1; i_address = 32'h500;
        step();
        check("bb_busy1", {31'd0, busy}, 32'd1);
        step();
        avm_readdata = 32'hA0A0A0A0;
        step();
        avm_readdata = 32'hBADBAD00;
        check("bb_done1", {31'd0, i_done}, 32'd1);
        check("bb_rdata1", i_readdata, 32'hA0A0A0A0);
        check("bb_busy_done", {31'd0, busy}, 32'd1);
        step();
        check("bb_idle_busy", {31'd0, busy}, 32'd0);
        check("bb_idle_strobe", {31'd0, avm_read}, 32'd0);
        step();
        serve_read(1'b0, 32'h500, 32'hB0B0B0B0, "bb2");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
